serial_bus_arbiter: RTL and testbench

Parametrised N-master arbiter for the shared serial bus; it generalises the fixed two-master arrangement to `NUM_MASTERS` masters.
- Grants the bus to one master at a time using round-robin or fixed priority.
- Holds the grant for the full burst.
- Supports slave split and release of parked masters.
- Revokes a stalled grant through a watchdog.
- Sits between the master request ports and the shared address/data mux; its one-hot grant drives that mux select.

---
 rtl/serial_bus_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/serial_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_serial_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int BURST_SIZE_DEF = 12;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: round-robin from ptr, or lowest index when fixed.
module rr_priority_picker
  import serial_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  input  logic          fixed,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int start;
  int c;

  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    c      = 0;
    start  = fixed ? 0 : int'(ptr);
    if (start >= N) start = 0;
    for (int k = 0; k < N; k++) begin
      c = start + k;
      if (c >= N) c = c - N;
      if (!valid && eligible[c]) begin
        valid     = 1'b1;
        idx       = IW'(c);
        winner[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// N-master serial bus arbiter: burst hold, slave split parking, stall watchdog.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int BURST_SIZE     = BURST_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                                    clock,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic [NUM_MASTERS-1:0]                  req,
  input  logic [NUM_MASTERS*(BURST_SIZE+1)-1:0]   burst_num,
  input  logic                                    beat,
  input  logic                                    split,
  input  logic [NUM_MASTERS-1:0]                  split_release,
  output logic [NUM_MASTERS-1:0]                  grant,
  output logic [idx_w(NUM_MASTERS)-1:0]           grant_idx,
  output logic                                    bus_busy,
  output logic [NUM_MASTERS-1:0]                  m_busy,
  output logic                                    timeout,
  output logic [1:0]                              arb_state
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int BW = BURST_SIZE + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_GRANTED = GRANTED;
  localparam logic [1:0] S_RELEASE = RELEASE;

  logic [1:0]             state;
  logic [IW-1:0]          ptr;
  logic [NUM_MASTERS-1:0] parked;
  logic [NUM_MASTERS-1:0] park_set;
  logic [BW-1:0]          beat_cnt;
  logic [WW-1:0]          wdog;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [BW-1:0]          burst_sel;
  logic                   req_w;
  logic                   last_beat;

  assign eligible  = req & ~parked;
  assign req_w     = |(req & grant);
  assign last_beat = beat && (beat_cnt == '0);

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .fixed    (FIXED_PRIORITY != 0),
    .winner   (pick_oh),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    burst_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) burst_sel = burst_num[i*BW +: BW];
    end
  end

  // A final beat wins over split, so only a mid-burst split parks the master.
  always_comb begin
    park_set = '0;
    if (state == S_GRANTED && split && !last_beat) park_set = grant;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      parked    <= '0;
      beat_cnt  <= '0;
      wdog      <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      parked  <= (parked & ~split_release) | park_set;
      case (state)
        S_IDLE: begin
          if (enable && pick_valid) begin
            state     <= S_GRANTED;
            grant     <= pick_oh;
            grant_idx <= pick_idx;
            beat_cnt  <= burst_sel;
            wdog      <= '0;
            if (FIXED_PRIORITY == 0)
              ptr <= (pick_idx == IW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        S_GRANTED: begin
          if (last_beat || split || !req_w) begin
            state <= S_RELEASE;
            grant <= '0;
          end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            state   <= S_RELEASE;
            grant   <= '0;
            timeout <= 1'b1;
          end else if (beat) begin
            beat_cnt <= beat_cnt - 1'b1;
            wdog     <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign bus_busy  = (state != S_IDLE);
  assign m_busy    = (req & ~grant) | parked;
  assign arb_state = state;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: vector table plus multi-cycle corner sequences.
module tb_serial_bus_arbiter;
  import serial_bus_pkg::*;

  localparam int BW = 5;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          enable;
  logic [3:0]    req;
  logic [4*BW-1:0] bn;
  logic          beat, split;
  logic [3:0]    srel;

  logic [3:0] g_rr, mb_rr, g_fp, mb_fp;
  logic [1:0] gi_rr, gi_fp, st_rr, st_fp, st_2;
  logic       bb_rr, to_rr, bb_fp, to_fp;
  logic [1:0] g_2, mb_2;
  logic [0:0] gi_2;
  logic       bb_2, to_2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_bus_arbiter #(.NUM_MASTERS(4), .BURST_SIZE(4), .TIMEOUT_CYCLES(8), .FIXED_PRIORITY(0)) u_rr (
    .clock(clock), .rst(rst), .enable(enable), .req(req), .burst_num(bn), .beat(beat),
    .split(split), .split_release(srel), .grant(g_rr), .grant_idx(gi_rr), .bus_busy(bb_rr),
    .m_busy(mb_rr), .timeout(to_rr), .arb_state(st_rr));

  serial_bus_arbiter #(.NUM_MASTERS(4), .BURST_SIZE(4), .TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1)) u_fp (
    .clock(clock), .rst(rst), .enable(enable), .req(req), .burst_num(bn), .beat(beat),
    .split(split), .split_release(srel), .grant(g_fp), .grant_idx(gi_fp), .bus_busy(bb_fp),
    .m_busy(mb_fp), .timeout(to_fp), .arb_state(st_fp));

  serial_bus_arbiter #(.NUM_MASTERS(2), .BURST_SIZE(4), .TIMEOUT_CYCLES(255), .FIXED_PRIORITY(0)) u_2 (
    .clock(clock), .rst(rst), .enable(enable), .req(req[1:0]), .burst_num(bn[2*BW-1:0]), .beat(beat),
    .split(split), .split_release(srel[1:0]), .grant(g_2), .grant_idx(gi_2), .bus_busy(bb_2),
    .m_busy(mb_2), .timeout(to_2), .arb_state(st_2));

  typedef struct packed {
    logic          rst;
    logic          en;
    logic [3:0]    req;
    logic [BW-1:0] b0;
    logic          beat;
    logic          split;
    logic [3:0]    srel;
    logic [3:0]    grant;
    logic [1:0]    gidx;
    logic          busy;
    logic [3:0]    mbusy;
    logic          tmo;
    logic [3:0]    fgrant;
    logic          chk2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [3:0] rq, input logic [BW-1:0] b0,
                     input logic bt, input logic sp, input logic [3:0] sr,
                     input logic [3:0] g, input logic [1:0] gi, input logic bb,
                     input logic [3:0] mb, input logic to, input logic [3:0] fg, input logic c2);
    vec_t v;
    v = '{r, e, rq, b0, bt, sp, sr, g, gi, bb, mb, to, fg, c2};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    enable = 1'b1; req = '0; beat = 1'b0; split = 1'b0; srel = '0; bn = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_burst(input int m, input int v);
    bn[m*BW +: BW] = BW'(v);
  endtask

  initial begin
    clear_in();

    // rst en req b0 beat split srel | grant gidx busy mbusy tmo fgrant chk2
    add(1,0,4'h0,0,0,0,0, 4'h0,0,0,4'h0,0,4'h0,1);
    add(0,1,4'h1,3,1,0,0, 4'h1,0,1,4'h0,0,4'h1,1);
    add(0,1,4'h1,3,1,0,0, 4'h1,0,1,4'h0,0,4'h1,1);
    add(0,1,4'h1,3,1,0,0, 4'h1,0,1,4'h0,0,4'h1,1);
    add(0,1,4'h1,3,1,0,0, 4'h1,0,1,4'h0,0,4'h1,1);
    add(0,1,4'h1,3,1,0,0, 4'h0,0,1,4'h1,0,4'h0,1);
    add(0,1,4'h0,3,0,0,0, 4'h0,0,0,4'h0,0,4'h0,1);
    add(1,0,4'h0,0,0,0,0, 4'h0,0,0,4'h0,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h1,0,1,4'hE,0,4'h1,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,0,1,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,0,0,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h2,1,1,4'hD,0,4'h1,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,1,1,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,1,0,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h4,2,1,4'hB,0,4'h1,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,2,1,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,2,0,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h8,3,1,4'h7,0,4'h1,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,3,1,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h0,3,0,4'hF,0,4'h0,0);
    add(0,1,4'hF,0,1,0,0, 4'h1,0,1,4'hE,0,4'h1,0);
    add(0,1,4'h0,0,1,0,0, 4'h0,0,1,4'h0,0,4'h0,0);
    add(0,1,4'h0,0,0,0,0, 4'h0,0,0,4'h0,0,4'h0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; req = tbl[i].req;
      bn = '0; bn[BW-1:0] = tbl[i].b0;
      beat = tbl[i].beat; split = tbl[i].split; srel = tbl[i].srel;
      tick();
      chk($sformatf("v%0d_grant", i), 32'(g_rr), 32'(tbl[i].grant));
      chk($sformatf("v%0d_gidx", i), 32'(gi_rr), 32'(tbl[i].gidx));
      chk($sformatf("v%0d_busy", i), 32'(bb_rr), 32'(tbl[i].busy));
      chk($sformatf("v%0d_mbusy", i), 32'(mb_rr), 32'(tbl[i].mbusy));
      chk($sformatf("v%0d_tmo", i), 32'(to_rr), 32'(tbl[i].tmo));
      chk($sformatf("v%0d_fp_grant", i), 32'(g_fp), 32'(tbl[i].fgrant));
      if (tbl[i].chk2) begin
        chk($sformatf("v%0d_n2_grant", i), 32'(g_2), 32'(tbl[i].grant[1:0]));
        chk($sformatf("v%0d_n2_busy", i), 32'(bb_2), 32'(tbl[i].busy));
        chk($sformatf("v%0d_n2_mbusy", i), 32'(mb_2), 32'(tbl[i].mbusy[1:0]));
      end
    end

    // Split mid-burst parks master 1; release pulse re-admits it with a full reload.
    do_reset();
    set_burst(1, 4); set_burst(0, 0);
    req = 4'b0010;
    tick(); chk("split_grant1", 32'(g_rr), 32'h2);
    beat = 1'b1;
    tick(); chk("split_beat1", 32'(g_rr), 32'h2);
    split = 1'b1;
    tick(); chk("split_release_grant", 32'(g_rr), 32'h0);
    chk("split_parked_mbusy", 32'(mb_rr[1]), 32'h1);
    split = 1'b0; beat = 1'b0; req = 4'b0011;
    tick(); chk("split_idle_mbusy", 32'(mb_rr), 32'h3);
    tick(); chk("split_skip_grant", 32'(g_rr), 32'h1);
    chk("split_skip_mbusy", 32'(mb_rr), 32'h2);
    req = 4'b0010; beat = 1'b1;
    tick(); chk("split_m0_done", 32'(g_rr), 32'h0);
    beat = 1'b0; srel = 4'b0010;
    tick(); chk("split_unpark_mbusy", 32'(mb_rr), 32'h2);
    srel = 4'b0000;
    tick(); chk("split_regrant", 32'(g_rr), 32'h2);
    chk("split_regrant_idx", 32'(gi_rr), 32'h1);
    beat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk($sformatf("split_reload_beat%0d", k), 32'(g_rr), 32'h2);
    end
    tick(); chk("split_reload_end", 32'(g_rr), 32'h0);
    beat = 1'b0; req = '0;
    tick();

    // Watchdog: no beats for 8 granted cycles.
    do_reset();
    set_burst(2, 3); req = 4'b0100;
    tick(); chk("tmo_grant", 32'(g_rr), 32'h4);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("tmo_hold%0d", k), 32'(g_rr), 32'h4);
      chk($sformatf("tmo_quiet%0d", k), 32'(to_rr), 32'h0);
    end
    tick(); chk("tmo_pulse", 32'(to_rr), 32'h1);
    chk("tmo_grant_drop", 32'(g_rr), 32'h0);
    req = '0;
    tick(); chk("tmo_pulse_end", 32'(to_rr), 32'h0);

    // Final beat coinciding with split completes without parking.
    do_reset();
    set_burst(3, 1); req = 4'b1000;
    tick(); chk("fs_grant", 32'(g_rr), 32'h8);
    beat = 1'b1;
    tick(); chk("fs_beat1", 32'(g_rr), 32'h8);
    split = 1'b1; req = 4'b0000;
    tick(); chk("fs_release", 32'(g_rr), 32'h0);
    chk("fs_not_parked", 32'(mb_rr), 32'h0);
    split = 1'b0; beat = 1'b0; req = 4'b1000;
    tick(); tick(); chk("fs_regrant", 32'(g_rr), 32'h8);
    req = '0;
    tick(); tick();

    // Enable low mid-burst lets the burst finish, then blocks new grants.
    do_reset();
    set_burst(0, 2); req = 4'b0001;
    tick(); chk("en_grant", 32'(g_rr), 32'h1);
    enable = 1'b0; beat = 1'b1;
    tick(); chk("en_hold1", 32'(g_rr), 32'h1);
    tick(); chk("en_hold2", 32'(g_rr), 32'h1);
    tick(); chk("en_release", 32'(g_rr), 32'h0);
    chk("en_release_busy", 32'(bb_rr), 32'h1);
    beat = 1'b0;
    tick(); chk("en_idle_busy", 32'(bb_rr), 32'h0);
    tick(); chk("en_no_grant", 32'(g_rr), 32'h0);
    chk("en_no_grant_busy", 32'(bb_rr), 32'h0);

    // Asynchronous reset mid-burst clears grant, parking and pointer.
    do_reset();
    set_burst(2, 3); set_burst(1, 3); req = 4'b0100;
    tick(); chk("rst_m2_grant", 32'(g_rr), 32'h4);
    split = 1'b1;
    tick(); split = 1'b0; req = 4'b0010;
    tick();
    tick(); chk("rst_m1_grant", 32'(g_rr), 32'h2);
    chk("rst_m2_parked", 32'(mb_rr), 32'h4);
    beat = 1'b1;
    tick();
    rst = 1'b1; req = '0; beat = 1'b0;
    #1;
    chk("rst_async_grant", 32'(g_rr), 32'h0);
    chk("rst_async_busy", 32'(bb_rr), 32'h0);
    chk("rst_async_parked", 32'(mb_rr), 32'h0);
    chk("rst_async_idx", 32'(gi_rr), 32'h0);
    tick();
    rst = 1'b0; bn = '0; req = 4'b1111;
    tick(); chk("rst_first_grant", 32'(g_rr), 32'h1);

    clear_in();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
